// File: rtl/local_bus_arbiter.sv
// Purpose: arbitrates 68040 local-bus ownership between the CPU (parked owner) and NUM_EXT external masters.
// Latency: every output is registered; a request is seen at one edge and answered on the next.
// Backpressure: an owner is never preempted mid-transfer; grants are withdrawn and the arbiter waits for nBB high.
//
// Ports:
//   BCLK, nRESET     bus clock (rising edge) and asynchronous active-low reset
//   nBR, nLOCK, nBB  CPU request, CPU locked sequence, shared bus-busy (all active low)
//   nREQ / nGNT      per-master request / grant (active low; grants one-hot-or-none)
//   nBG              CPU grant (active low); parked low whenever no external master is involved
//   OWNER            0 = CPU, 1..NUM_EXT = external master index+1, 7 = none / transition
//   GNT_TO           one-cycle pulse when a granted master fails to take the bus in time
module local_bus_arbiter #(
  parameter int NUM_EXT     = 2,
  parameter int GNT_TIMEOUT = 8,
  parameter int MAX_TENURE  = 64
) (
  input  logic               BCLK,
  input  logic               nRESET,
  input  logic               nBR,
  input  logic               nLOCK,
  input  logic               nBB,
  input  logic [NUM_EXT-1:0] nREQ,
  output logic               nBG,
  output logic [NUM_EXT-1:0] nGNT,
  output logic [2:0]         OWNER,
  output logic               GNT_TO
);

  localparam int IW = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1;
  localparam int CW = IW + 1;
  localparam int TW = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;
  localparam int MW = $clog2(MAX_TENURE + 1);

  typedef enum logic [2:0] {CPU_PARK, REVOKE, EXT_GRANT, EXT_OWN, HANDOFF} state_t;

  state_t             state, state_nx;
  logic [IW-1:0]      rr_ptr, rr_ptr_nx, cur_w, cur_w_nx;
  logic [TW-1:0]      to_cnt, to_cnt_nx;
  logic [MW-1:0]      ten_cnt, ten_cnt_nx;
  logic               nbg_nx, gnt_to_nx;
  logic [NUM_EXT-1:0] ngnt_nx;
  logic [2:0]         owner_nx;

  logic [NUM_EXT-1:0] req;
  logic               any_req, cur_req, others_wait;
  logic               sel_vld;
  logic [IW-1:0]      sel_idx, sel_nxt;
  logic [CW-1:0]      cand, nxt;

  assign req         = ~nREQ;
  assign any_req     = |req;
  assign cur_req     = req[cur_w];
  // CPU or any other master waiting makes the current owner's tenure limit bite.
  assign others_wait = ~nBR | (|(req & ~(NUM_EXT'(1) << cur_w)));

  // Round-robin pick: first requester at or after rr_ptr, which already points one
  // past the last granted master. Lowest offset wins, so the loop runs high to low.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = NUM_EXT - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= CW'(NUM_EXT)) cand = cand - CW'(NUM_EXT);
      if (req[cand[IW-1:0]]) begin
        sel_vld = 1'b1;
        sel_idx = cand[IW-1:0];
      end
    end
    nxt = {1'b0, sel_idx} + CW'(1);
    if (nxt >= CW'(NUM_EXT)) nxt = '0;
    sel_nxt = nxt[IW-1:0];
  end

  always_comb begin
    state_nx   = state;
    nbg_nx     = nBG;
    ngnt_nx    = nGNT;
    owner_nx   = OWNER;
    gnt_to_nx  = 1'b0;
    rr_ptr_nx  = rr_ptr;
    cur_w_nx   = cur_w;
    to_cnt_nx  = to_cnt;
    ten_cnt_nx = ten_cnt;
    case (state)
      CPU_PARK: begin
        nbg_nx   = 1'b0;
        owner_nx = 3'd0;
        // A locked CPU sequence must not be broken, so revocation waits for nLOCK.
        if (any_req && nLOCK) begin
          state_nx = REVOKE;
          nbg_nx   = 1'b1;
          owner_nx = 3'd7;
        end
      end
      REVOKE: begin
        if (nBB && nLOCK) begin
          if (sel_vld) begin
            state_nx  = EXT_GRANT;
            ngnt_nx   = ~(NUM_EXT'(1) << sel_idx);
            cur_w_nx  = sel_idx;
            rr_ptr_nx = sel_nxt;
            to_cnt_nx = '0;
          end else begin
            state_nx = CPU_PARK;
            nbg_nx   = 1'b0;
            owner_nx = 3'd0;
          end
        end
      end
      EXT_GRANT: begin
        to_cnt_nx = to_cnt + TW'(1);
        if (!nBB) begin
          state_nx   = EXT_OWN;
          owner_nx   = 3'(cur_w) + 3'd1;
          ten_cnt_nx = '0;
        end else if (!cur_req || to_cnt == TW'(GNT_TIMEOUT - 1)) begin
          // A dropped request is a clean withdrawal, not a timeout.
          state_nx  = REVOKE;
          ngnt_nx   = '1;
          gnt_to_nx = cur_req;
        end
      end
      EXT_OWN: begin
        if (ten_cnt < MW'(MAX_TENURE)) ten_cnt_nx = ten_cnt + MW'(1);
        if (!cur_req || (others_wait && ten_cnt >= MW'(MAX_TENURE))) ngnt_nx = '1;
        // Only hand off once the grant is already down and the master has let go.
        if (nBB && nGNT[cur_w]) begin
          state_nx = HANDOFF;
          owner_nx = 3'd7;
          ngnt_nx  = '1;
        end
      end
      HANDOFF: begin
        if (!nBR || !sel_vld) begin
          state_nx = CPU_PARK;
          nbg_nx   = 1'b0;
          owner_nx = 3'd0;
        end else begin
          state_nx  = EXT_GRANT;
          ngnt_nx   = ~(NUM_EXT'(1) << sel_idx);
          cur_w_nx  = sel_idx;
          rr_ptr_nx = sel_nxt;
          to_cnt_nx = '0;
        end
      end
      default: begin
        state_nx = CPU_PARK;
        nbg_nx   = 1'b0;
        ngnt_nx  = '1;
        owner_nx = 3'd0;
      end
    endcase
  end

  always_ff @(posedge BCLK or negedge nRESET) begin
    if (!nRESET) begin
      state   <= CPU_PARK;
      nBG     <= 1'b0;
      nGNT    <= '1;
      OWNER   <= 3'd0;
      GNT_TO  <= 1'b0;
      rr_ptr  <= '0;
      cur_w   <= '0;
      to_cnt  <= '0;
      ten_cnt <= '0;
    end else begin
      state   <= state_nx;
      nBG     <= nbg_nx;
      nGNT    <= ngnt_nx;
      OWNER   <= owner_nx;
      GNT_TO  <= gnt_to_nx;
      rr_ptr  <= rr_ptr_nx;
      cur_w   <= cur_w_nx;
      to_cnt  <= to_cnt_nx;
      ten_cnt <= ten_cnt_nx;
    end
  end

endmodule
